// File: rtl/wb_trace_buffer_if.sv
// Bus bundle for the writeback trace buffer.
// Carries the writeback-side inputs, the trigger/clear controls, the drain
// handshake with its head record, and the status counters. clk and reset
// are scalar ports on the module and are not part of this bundle.
interface wb_trace_buffer_if #(
    parameter int PTR_W = 4
);
    // Writeback stage debug outputs
    logic              wb_valid;
    logic              wb_over;
    logic [31:0]       wb_pc;
    logic              wb_wen;
    logic [4:0]        wb_wdest;
    logic [31:0]       wb_wdata;

    // Stop-on-PC trigger and synchronous clear
    logic              trig_en;
    logic [31:0]       trig_pc;
    logic              clear;

    // Drain side: show-ahead head record with valid/ready handshake
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_pc;
    logic              out_wen;
    logic [4:0]        out_wdest;
    logic [31:0]       out_wdata;

    // Status
    logic [31:0]       retire_cnt;
    logic [15:0]       drop_cnt;
    logic              overflow;
    logic              stopped;
    logic [PTR_W:0]    count;

    // Producer / consumer / observer side (CPU, bench, debug host)
    modport master (
        output wb_valid, wb_over, wb_pc, wb_wen, wb_wdest, wb_wdata,
        output trig_en, trig_pc, clear,
        output out_ready,
        input  out_valid, out_pc, out_wen, out_wdest, out_wdata,
        input  retire_cnt, drop_cnt, overflow, stopped, count
    );

    // The trace buffer itself
    modport slave (
        input  wb_valid, wb_over, wb_pc, wb_wen, wb_wdest, wb_wdata,
        input  trig_en, trig_pc, clear,
        input  out_ready,
        output out_valid, out_pc, out_wen, out_wdest, out_wdata,
        output retire_cnt, drop_cnt, overflow, stopped, count
    );
endinterface

// File: rtl/wb_trace_buffer.sv
// Writeback trace buffer.
// Captures one 70-bit record per retired instruction into a show-ahead FIFO
// and drains it over valid/ready. Keeps a retire counter (counts every
// retirement, captured or not), a saturating drop counter with a sticky
// overflow flag, and a stop-on-PC trigger that freezes capture until clear
// or reset. The only state machine is RUN/STOPPED.
module wb_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic         clk,
    input  logic         reset,
    wb_trace_buffer_if.slave bus
);

    // Record layout: {pc[31:0], wen, wdest[4:0], wdata[31:0]}
    localparam int REC_W = 70;
    localparam int PC_LSB    = 38;
    localparam int WEN_BIT   = 37;
    localparam int DEST_LSB  = 32;

    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [15:0]      DROP_MAX   = 16'hFFFF;

    typedef enum logic {
        CAP_RUN     = 1'b0,
        CAP_STOPPED = 1'b1
    } cap_state_t;

    // Storage and state
    logic [REC_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [PTR_W:0]    count_reg, count_next;
    logic [31:0]       retire_cnt_reg, retire_cnt_next;
    logic [15:0]       drop_cnt_reg, drop_cnt_next;
    logic              overflow_reg, overflow_next;
    cap_state_t        state_reg, state_next;

    // Event decode
    logic              retire;
    logic              not_empty;
    logic              full;
    logic              pop;
    logic              capture_ok;
    logic              push;
    logic              drop;
    logic              trig_hit;
    logic [REC_W-1:0]  wr_rec;
    logic [REC_W-1:0]  head_rec;

    // Decode retire/push/pop/drop/trigger events for this cycle
    always_comb begin
        retire     = bus.wb_valid & bus.wb_over;
        not_empty  = (count_reg != '0);
        full       = (count_reg == FULL_COUNT);
        pop        = not_empty & bus.out_ready;
        capture_ok = retire & (state_reg == CAP_RUN);
        // A pop in the same cycle frees the slot, so a full FIFO still accepts
        push       = capture_ok & (~full | pop);
        drop       = capture_ok & full & ~pop;
        trig_hit   = capture_ok & bus.trig_en & (bus.wb_pc == bus.trig_pc);
        // Unwritten destination/data are zeroed at capture so the stored
        // record is already in its final form
        wr_rec     = {bus.wb_pc,
                      bus.wb_wen,
                      bus.wb_wen ? bus.wb_wdest : 5'd0,
                      bus.wb_wen ? bus.wb_wdata : 32'd0};
    end

    // Record storage; no reset needed since pointers/count gate every read
    always_ff @(posedge clk) begin
        if (push && !bus.clear) begin
            mem[wr_ptr_reg] <= wr_rec;
        end
    end

    // Show-ahead head read straight from storage
    always_comb begin
        head_rec = mem[rd_ptr_reg];
    end

    // Next-state for pointers, occupancy and counters; clear wins over push/pop
    always_comb begin
        wr_ptr_next     = wr_ptr_reg;
        rd_ptr_next     = rd_ptr_reg;
        count_next      = count_reg;
        retire_cnt_next = retire_cnt_reg;
        drop_cnt_next   = drop_cnt_reg;
        overflow_next   = overflow_reg;

        if (bus.clear) begin
            wr_ptr_next     = '0;
            rd_ptr_next     = '0;
            count_next      = '0;
            retire_cnt_next = '0;
            drop_cnt_next   = '0;
            overflow_next   = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CNT_ONE;
                2'b01:   count_next = count_reg - CNT_ONE;
                default: count_next = count_reg;
            endcase
            // Every retirement counts, even while stopped or full
            if (retire) begin
                retire_cnt_next = retire_cnt_reg + 32'd1;
            end
            if (drop) begin
                overflow_next = 1'b1;
                if (drop_cnt_reg != DROP_MAX) begin
                    drop_cnt_next = drop_cnt_reg + 16'd1;
                end
            end
        end
    end

    // Datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            retire_cnt_reg <= '0;
            drop_cnt_reg   <= '0;
            overflow_reg   <= 1'b0;
        end else begin
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            count_reg      <= count_next;
            retire_cnt_reg <= retire_cnt_next;
            drop_cnt_reg   <= drop_cnt_next;
            overflow_reg   <= overflow_next;
        end
    end

    // Capture state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= CAP_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Capture next state: a trigger match stops capture; only clear restarts
    always_comb begin
        state_next = state_reg;
        if (bus.clear) begin
            state_next = CAP_RUN;
        end else if (trig_hit) begin
            state_next = CAP_STOPPED;
        end
    end

    // Capture state outputs
    always_comb begin
        bus.stopped = (state_reg == CAP_STOPPED);
    end

    // Drive the head record and status; record fields read as zero when empty
    always_comb begin
        bus.out_valid  = not_empty;
        bus.out_pc     = not_empty ? head_rec[PC_LSB +: 32]  : 32'd0;
        bus.out_wen    = not_empty ? head_rec[WEN_BIT]       : 1'b0;
        bus.out_wdest  = not_empty ? head_rec[DEST_LSB +: 5] : 5'd0;
        bus.out_wdata  = not_empty ? head_rec[31:0]          : 32'd0;
        bus.retire_cnt = retire_cnt_reg;
        bus.drop_cnt   = drop_cnt_reg;
        bus.overflow   = overflow_reg;
        bus.count      = count_reg;
    end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_wb_trace_buffer;

    localparam int DEPTH = 16;
    localparam int PTR_W = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    wb_trace_buffer_if #(.PTR_W(PTR_W)) bus ();

    wb_trace_buffer #(
        .DEPTH(DEPTH),
        .PTR_W(PTR_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a queue of records plus plain counters
    typedef struct {
        logic [31:0] pc;
        logic        wen;
        logic [4:0]  wdest;
        logic [31:0] wdata;
    } rec_t;

    rec_t        mq[$];
    logic [31:0] m_retire;
    int          m_drop;
    bit          m_ovf;
    bit          m_stop;

    function automatic void model_reset();
        mq.delete();
        m_retire = 32'd0;
        m_drop   = 0;
        m_ovf    = 1'b0;
        m_stop   = 1'b0;
    endfunction

    function automatic rec_t exp_head();
        rec_t r;
        r.pc = 32'd0; r.wen = 1'b0; r.wdest = 5'd0; r.wdata = 32'd0;
        if (mq.size() != 0) r = mq[0];
        return r;
    endfunction

    task automatic idle_inputs();
        bus.wb_valid = 1'b0;
        bus.wb_over  = 1'b0;
        bus.wb_pc    = 32'd0;
        bus.wb_wen   = 1'b0;
        bus.wb_wdest = 5'd0;
        bus.wb_wdata = 32'd0;
        bus.clear    = 1'b0;
    endtask

    task automatic set_retire(input logic [31:0] pc, input logic wen,
                              input logic [4:0] dest, input logic [31:0] data);
        bus.wb_valid = 1'b1;
        bus.wb_over  = 1'b1;
        bus.wb_pc    = pc;
        bus.wb_wen   = wen;
        bus.wb_wdest = dest;
        bus.wb_wdata = data;
    endtask

    // Apply the current inputs to the model, then advance one clock edge
    task automatic cycle();
        bit   retire;
        rec_t r;
        if (bus.clear) begin
            model_reset();
            $display("[%0t] clear", $time);
        end else begin
            retire = bus.wb_valid && bus.wb_over;
            if ((mq.size() != 0) && bus.out_ready) begin
                r = mq.pop_front();
                $display("[%0t] pop  pc=%08h wen=%0d dest=%0d data=%08h",
                         $time, r.pc, r.wen, r.wdest, r.wdata);
            end
            if (retire) m_retire = m_retire + 32'd1;
            if (retire && !m_stop) begin
                if (mq.size() < DEPTH) begin
                    r.pc    = bus.wb_pc;
                    r.wen   = bus.wb_wen;
                    r.wdest = bus.wb_wen ? bus.wb_wdest : 5'd0;
                    r.wdata = bus.wb_wen ? bus.wb_wdata : 32'd0;
                    mq.push_back(r);
                    $display("[%0t] push pc=%08h wen=%0d", $time, r.pc, r.wen);
                end else begin
                    if (m_drop < 65535) m_drop++;
                    m_ovf = 1'b1;
                    $display("[%0t] drop pc=%08h", $time, bus.wb_pc);
                end
                if (bus.trig_en && (bus.wb_pc == bus.trig_pc)) begin
                    m_stop = 1'b1;
                    $display("[%0t] trigger pc=%08h", $time, bus.wb_pc);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        idle_inputs();
        bus.clear = 1'b1;
        cycle();
        bus.clear = 1'b0;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        idle_inputs();
        bus.out_ready = 1'b0;
        bus.trig_en   = 1'b0;
        bus.trig_pc   = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
        n_checks++;
        if (bus.count !== '0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        n_checks++;
        if (bus.retire_cnt !== 32'd0 || bus.drop_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_counters got retire=%0d drop=%0d exp 0/0", bus.retire_cnt, bus.drop_cnt);
        end
        n_checks++;
        if (bus.overflow !== 1'b0 || bus.stopped !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags got ovf=%0b stop=%0b exp 0/0", bus.overflow, bus.stopped);
        end
        n_checks++;
        if (bus.out_pc !== 32'd0 || bus.out_wdata !== 32'd0) begin
            n_fail++; $display("FAIL reset_record got pc=%08h data=%08h exp 0/0", bus.out_pc, bus.out_wdata);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] bdata [3];
        bdata[0] = 32'h11; bdata[1] = 32'h22; bdata[2] = 32'h33;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_retire(32'(i * 4), 1'b1, 5'(i + 1), bdata[i]);
            cycle();
        end
        idle_inputs();
        n_checks++;
        if (bus.count !== 5'd3) begin n_fail++; $display("FAIL basic_count got=%0d exp=3", bus.count); end
        n_checks++;
        if (bus.retire_cnt !== 32'd3) begin n_fail++; $display("FAIL basic_retire got=%0d exp=3", bus.retire_cnt); end
        n_checks++;
        if (bus.out_pc !== 32'h0 || bus.out_wen !== 1'b1 || bus.out_wdest !== 5'd1 || bus.out_wdata !== 32'h11) begin
            n_fail++;
            $display("FAIL basic_head got {%08h,%0b,%0d,%08h} exp {00000000,1,1,00000011}",
                     bus.out_pc, bus.out_wen, bus.out_wdest, bus.out_wdata);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(i * 4) || bus.out_wdest !== 5'(i + 1) || bus.out_wdata !== bdata[i]) begin
                n_fail++;
                $display("FAIL basic_drain%0d got v=%0b pc=%08h dest=%0d data=%08h exp v=1 pc=%08h dest=%0d data=%08h",
                         i, bus.out_valid, bus.out_pc, bus.out_wdest, bus.out_wdata, 32'(i * 4), i + 1, bdata[i]);
            end
            cycle();
        end
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_empty got out_valid=%0b exp=0", bus.out_valid); end
    endtask

    task automatic test_masking();
        bus.out_ready = 1'b0;
        set_retire(32'h0C, 1'b0, 5'd7, 32'hDEAD);
        cycle();
        idle_inputs();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0C) begin
            n_fail++; $display("FAIL mask_head got v=%0b pc=%08h exp v=1 pc=0000000c", bus.out_valid, bus.out_pc);
        end
        n_checks++;
        if (bus.out_wen !== 1'b0 || bus.out_wdest !== 5'd0 || bus.out_wdata !== 32'd0) begin
            n_fail++; $display("FAIL mask_fields got wen=%0b dest=%0d data=%08h exp 0/0/0", bus.out_wen, bus.out_wdest, bus.out_wdata);
        end
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        pulse_clear();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            set_retire(32'(i * 4), 1'b1, 5'(i), 32'(i) + 32'h100);
            cycle();
        end
        idle_inputs();
        n_checks++;
        if (bus.count !== 5'd16) begin n_fail++; $display("FAIL ovf_count got=%0d exp=16", bus.count); end
        n_checks++;
        if (bus.drop_cnt !== 16'd4) begin n_fail++; $display("FAIL ovf_drop got=%0d exp=4", bus.drop_cnt); end
        n_checks++;
        if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%0b exp=1", bus.overflow); end
        n_checks++;
        if (bus.retire_cnt !== 32'd20) begin n_fail++; $display("FAIL ovf_retire got=%0d exp=20", bus.retire_cnt); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (bus.out_pc !== 32'(i * 4)) begin
                n_fail++; $display("FAIL ovf_drain%0d got pc=%08h exp=%08h", i, bus.out_pc, 32'(i * 4));
            end
            cycle();
        end
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_after got v=%0b ovf=%0b exp v=0 ovf=1", bus.out_valid, bus.overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] exp_pc;
        pulse_clear();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            set_retire(32'h200 + 32'(i * 4), 1'b1, 5'd3, 32'(i));
            cycle();
        end
        n_checks++;
        if (bus.count !== 5'd16) begin n_fail++; $display("FAIL fpp_fill got=%0d exp=16", bus.count); end
        set_retire(32'h300, 1'b1, 5'd9, 32'hCAFE);
        bus.out_ready = 1'b1;
        cycle();
        idle_inputs();
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.drop_cnt !== 16'd0 || bus.overflow !== 1'b0) begin
            n_fail++; $display("FAIL fpp_nodrop got drop=%0d ovf=%0b exp 0/0", bus.drop_cnt, bus.overflow);
        end
        n_checks++;
        if (bus.count !== 5'd16) begin n_fail++; $display("FAIL fpp_count got=%0d exp=16", bus.count); end
        n_checks++;
        if (bus.out_pc !== 32'h204) begin n_fail++; $display("FAIL fpp_head got=%08h exp=00000204", bus.out_pc); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_pc = (i < 15) ? 32'h204 + 32'(i * 4) : 32'h300;
            n_checks++;
            if (bus.out_pc !== exp_pc) begin
                n_fail++; $display("FAIL fpp_drain%0d got pc=%08h exp=%08h", i, bus.out_pc, exp_pc);
            end
            cycle();
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_trigger();
        pulse_clear();
        bus.out_ready = 1'b0;
        bus.trig_en   = 1'b1;
        bus.trig_pc   = 32'h08;
        for (int i = 0; i < 4; i++) begin
            set_retire(32'(i * 4), 1'b1, 5'd1, 32'(i));
            cycle();
        end
        idle_inputs();
        n_checks++;
        if (bus.count !== 5'd3) begin n_fail++; $display("FAIL trig_count got=%0d exp=3", bus.count); end
        n_checks++;
        if (bus.stopped !== 1'b1) begin n_fail++; $display("FAIL trig_stopped got=%0b exp=1", bus.stopped); end
        n_checks++;
        if (bus.retire_cnt !== 32'd4) begin n_fail++; $display("FAIL trig_retire got=%0d exp=4", bus.retire_cnt); end
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.count !== 5'd2 || bus.out_pc !== 32'h04) begin
            n_fail++; $display("FAIL trig_drain got count=%0d pc=%08h exp 2/00000004", bus.count, bus.out_pc);
        end
        bus.trig_en = 1'b0;
        pulse_clear();
        n_checks++;
        if (bus.count !== '0 || bus.retire_cnt !== 32'd0 || bus.drop_cnt !== 16'd0 || bus.stopped !== 1'b0 || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL trig_clear got count=%0d retire=%0d drop=%0d stop=%0b ovf=%0b exp all 0",
                     bus.count, bus.retire_cnt, bus.drop_cnt, bus.stopped, bus.overflow);
        end
        set_retire(32'h40, 1'b1, 5'd2, 32'h77);
        cycle();
        idle_inputs();
        n_checks++;
        if (bus.count !== 5'd1 || bus.out_pc !== 32'h40) begin
            n_fail++; $display("FAIL trig_resume got count=%0d pc=%08h exp 1/00000040", bus.count, bus.out_pc);
        end
    endtask

    task automatic test_random();
        rec_t h;
        int   ready_pct;
        pulse_clear();
        for (int c = 0; c < 600; c++) begin
            case ((c / 100) % 3)
                0:       ready_pct = 15;
                1:       ready_pct = 85;
                default: ready_pct = 50;
            endcase
            bus.wb_valid  = ($urandom_range(0, 3) != 0);
            bus.wb_over   = ($urandom_range(0, 3) != 0);
            bus.wb_pc     = 32'($urandom_range(0, 15)) * 32'd4;
            bus.wb_wen    = 1'($urandom_range(0, 1));
            bus.wb_wdest  = 5'($urandom_range(0, 31));
            bus.wb_wdata  = $urandom;
            bus.out_ready = ($urandom_range(0, 99) < ready_pct);
            bus.trig_en   = ($urandom_range(0, 15) == 0);
            bus.trig_pc   = 32'($urandom_range(0, 15)) * 32'd4;
            bus.clear     = ($urandom_range(0, 99) == 0);
            cycle();
            h = exp_head();
            n_checks++;
            if (bus.count !== 5'(mq.size()) || bus.out_valid !== (mq.size() != 0)) begin
                n_fail++; $display("FAIL rnd_count c=%0d got count=%0d v=%0b exp count=%0d", c, bus.count, bus.out_valid, mq.size());
            end
            n_checks++;
            if (bus.out_pc !== h.pc || bus.out_wen !== h.wen || bus.out_wdest !== h.wdest || bus.out_wdata !== h.wdata) begin
                n_fail++;
                $display("FAIL rnd_head c=%0d got {%08h,%0b,%0d,%08h} exp {%08h,%0b,%0d,%08h}", c,
                         bus.out_pc, bus.out_wen, bus.out_wdest, bus.out_wdata, h.pc, h.wen, h.wdest, h.wdata);
            end
            n_checks++;
            if (bus.retire_cnt !== m_retire || bus.drop_cnt !== 16'(m_drop)) begin
                n_fail++; $display("FAIL rnd_counters c=%0d got retire=%0d drop=%0d exp retire=%0d drop=%0d",
                                   c, bus.retire_cnt, bus.drop_cnt, m_retire, m_drop);
            end
            n_checks++;
            if (bus.overflow !== m_ovf || bus.stopped !== m_stop) begin
                n_fail++; $display("FAIL rnd_flags c=%0d got ovf=%0b stop=%0b exp ovf=%0b stop=%0b",
                                   c, bus.overflow, bus.stopped, m_ovf, m_stop);
            end
        end
        idle_inputs();
        bus.trig_en   = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        pulse_clear();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_retire(32'h500 + 32'(i * 4), 1'b1, 5'd4, 32'(i));
            cycle();
        end
        idle_inputs();
        n_checks++;
        if (bus.count !== 5'd5) begin n_fail++; $display("FAIL areset_pre got count=%0d exp=5", bus.count); end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.count !== '0) begin
            n_fail++; $display("FAIL areset_fifo got v=%0b count=%0d exp 0/0", bus.out_valid, bus.count);
        end
        n_checks++;
        if (bus.retire_cnt !== 32'd0 || bus.out_pc !== 32'd0) begin
            n_fail++; $display("FAIL areset_cnt got retire=%0d pc=%08h exp 0/0", bus.retire_cnt, bus.out_pc);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_masking();
        test_overflow();
        test_full_push_pop();
        test_trigger();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_trace_buffer.md
Name: wb_trace_buffer

Overview:
- Sits directly downstream of the pipeline_cpu writeback stage; consumes its WB debug outputs (WB_pc, write destination, write data, WB valid).
- Captures one trace record per retired instruction into a FIFO and drains it to a log or display consumer over a valid/ready handshake.
- Also keeps a retire counter, a sticky overflow flag with a drop count, and an optional stop-on-PC trigger, so benches and board debug can inspect the committed instruction stream.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256.
- PTR_W, 4, log2(DEPTH); pointer width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- wb_valid  in  1  WB stage holds a valid instruction.
- wb_over  in  1  WB stage completes this cycle; retire = wb_valid & wb_over.
- wb_pc  in  32  PC of the retiring instruction.
- wb_wen  in  1  register-file write enable of the retiring instruction.
- wb_wdest  in  5  destination register.
- wb_wdata  in  32  write data.
- trig_en  in  1  enables stop-on-PC.
- trig_pc  in  32  trigger PC.
- clear  in  1  synchronous clear of FIFO, counters and flags.
- out_valid  out  1  head record available.
- out_ready  in  1  consumer accepts the head record.
- out_pc  out  32  head record PC.
- out_wen  out  1  head record write enable.
- out_wdest  out  5  head record destination; 0 when out_wen=0.
- out_wdata  out  32  head record data; 0 when out_wen=0.
- retire_cnt  out  32  total retirements seen, including dropped ones.
- drop_cnt  out  16  records dropped while full; saturates at 16'hFFFF.
- overflow  out  1  sticky; set on the first drop.
- stopped  out  1  sticky; capture halted by the trigger.
- count  out  PTR_W+1  current occupancy.

Behaviour:
- Reset (async, any time): pointers = 0, count = 0, retire_cnt = 0, drop_cnt = 0, overflow = 0, stopped = 0, out_valid = 0. Record outputs read as 0 while empty.
- Retire event: retire = wb_valid & wb_over, sampled on the rising edge. retire_cnt increments on every retire, including while stopped or full. It wraps at 2^32.
- Record: {wb_pc, wb_wen, wb_wen ? wb_wdest : 0, wb_wen ? wb_wdata : 0}, 70 bits.
- Capture: a record is written when retire & ~stopped & (not full, or a pop occurs in the same cycle).
- Drop: retire & ~stopped & full & ~pop. Increments drop_cnt (saturating) and sets overflow. Nothing is written.
- Output interface:
  - FIFO is show-ahead: out_* reflect the head entry combinationally from storage; out_valid = (count != 0).
  - pop = out_valid & out_ready.
  - out_* must stay stable while out_valid=1 and out_ready=0.
- Write latency: a record written on edge N is visible at out_* after edge N (next cycle). There is no same-cycle bypass when empty.
- Simultaneous push and pop: count is unchanged, both pointers advance, and the stored entry and head stay consistent.
- Full with push and pop in the same cycle: the push is accepted and no drop occurs.
- Pointers are PTR_W bits and wrap modulo DEPTH. Full is count == DEPTH; empty is count == 0.
- Trigger:
  - If trig_en & retire & ~stopped & (wb_pc == trig_pc), the matching record is captured (or dropped if full, per the rules above), then stopped is set on that edge.
  - Later retires are not captured.
  - The FIFO keeps draining while stopped.
- clear (synchronous) has the same effect as reset, except it acts only on a clock edge. It has priority over push and pop in the same cycle.
- No state machine beyond the RUN/STOPPED state held in stopped: RUN goes to STOPPED on a trigger match; STOPPED goes to RUN only on clear or reset.

Test Plan:
- Basic capture. After reset, three retires: pc 0x00, 0x04, 0x08, each wen=1, wdest=1,2,3, wdata=0x11,0x22,0x33, with out_ready=0. Required: count=3, retire_cnt=3, head {0x00,1,1,0x11}. Then hold out_ready=1 for 3 cycles. Required: records pop out in order, out_valid ends at 0.
- Masking. Retire pc 0x0C with wen=0, wdest=7, wdata=0xDEAD. Required: out_wen=0, out_wdest=0, out_wdata=0.
- Overflow. DEPTH=16, out_ready=0, 20 retires with pc 0x00..0x4C. Required: count=16, drop_cnt=4, overflow=1, retire_cnt=20. Draining yields pc 0x00..0x3C; overflow stays 1.
- Full with simultaneous push and pop. With the FIFO full, one cycle with retire and out_ready=1. Required: drop_cnt unchanged, count stays 16, the new record is at the tail, the head advances by one.
- Trigger. trig_en=1, trig_pc=0x08, retires at 0x00, 0x04, 0x08, 0x0C. Required: 3 records captured, stopped=1, retire_cnt=4. Then pulse clear. Required: all counters 0, stopped=0, capture resumes.
- Async reset. Assert reset mid-stream while count=5, between clock edges. Required: out_valid=0, count=0, retire_cnt=0 immediately, before the next edge.
